// File: rtl/dft_scan_unloader.sv
// Purpose : per-chain scan unload engine; rotates the chain once and packs the bits LSB-first into words.
// Latency : ACK one cycle after the request; word k strobes 32(k+1)+2 cycles after the request; commit follows the drain.
// Backpr. : none on the word strobe; the engine stays in commit until dft_commit_ack.
module dft_scan_unloader #(
    parameter int p_chain_len  = 100,
    parameter int p_word_width = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dft_val_op,
    output logic                    dft_op_ack,
    output logic                    dft_op_commit,
    input  logic                    dft_commit_ack,
    output logic                    dft_output_strobe,
    output logic [p_word_width-1:0] dft_output_data,
    output logic                    scan_en,
    input  logic                    scan_out,
    output logic                    scan_in
);
    // The counter must be able to hold p_chain_len itself, so it never wraps.
    localparam int CW = $clog2(p_chain_len + 1);
    localparam int IW = $clog2(p_word_width);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACK    = 3'd1,
        S_SHIFT  = 3'd2,
        S_DRAIN  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_bit_cnt;
    logic [p_word_width-1:0] r_pack;
    logic [p_word_width-1:0] r_data;
    logic                    r_strobe;
    logic [IW-1:0]           w_bit_idx;
    logic [p_word_width-1:0] w_pack_cap;
    logic                    w_last_bit;
    logic                    w_word_full;

    // Bit position inside the current word, and the word with this cycle's bit merged in.
    assign w_bit_idx   = IW'(32'(r_bit_cnt) % p_word_width);
    assign w_pack_cap  = r_pack | ({{(p_word_width-1){1'b0}}, scan_out} << w_bit_idx);
    assign w_last_bit  = (r_bit_cnt == CW'(p_chain_len - 1));
    assign w_word_full = (w_bit_idx == IW'(p_word_width - 1));

    // Recirculate the chain so its contents survive the unload.
    assign scan_in           = scan_out;
    assign dft_output_strobe = r_strobe;
    assign dft_output_data   = r_data;

    // State register; reset drops straight to IDLE, which also drops scan_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; val_op is only looked at in IDLE and commit_ack only in COMMIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (dft_val_op)     w_state_nxt = S_ACK;
            S_ACK:                        w_state_nxt = S_SHIFT;
            S_SHIFT:  if (w_last_bit)     w_state_nxt = S_DRAIN;
            S_DRAIN:                      w_state_nxt = S_COMMIT;
            S_COMMIT: if (dft_commit_ack) w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and scan-enable outputs decoded from the state alone.
    always_comb begin
        dft_op_ack    = (r_state == S_ACK);
        dft_op_commit = (r_state == S_COMMIT);
        scan_en       = (r_state == S_SHIFT);
    end

    // Bit counter, packing register and registered word output.
    // A full word or the final chain bit loads the output register for a one-cycle strobe;
    // the final bit's strobe therefore lands in DRAIN, and a word that is both full and
    // final is strobed only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_pack    <= '0;
            r_strobe  <= 1'b0;
            r_data    <= '0;
        end else begin
            r_strobe <= 1'b0;
            r_data   <= '0;
            case (r_state)
                S_ACK: begin
                    r_bit_cnt <= '0;
                    r_pack    <= '0;
                end
                S_SHIFT: begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_last_bit || w_word_full) begin
                        r_strobe <= 1'b1;
                        r_data   <= w_pack_cap;
                        r_pack   <= '0;
                    end else begin
                        r_pack   <= w_pack_cap;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dft_scan_unloader.sv
// Bench for dft_scan_unloader: a 100-bit and a 64-bit instance, each with a behavioural
// recirculating scan chain, driven by directed handshake sequences.
module tb_dft_scan_unloader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  val_op, commit_ack, ack, commit, strb, sen, sout, sin, ld_req;
    logic [1:0][31:0] data;
    logic [99:0] ch100 = '0;
    logic [99:0] ld100;
    logic [63:0] ch64 = '0;
    logic [63:0] ld64;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [8];
    int          scyc  [8];
    int          n_strb, commit_cyc, end_cyc, ack_cnt, ack_cyc, overlap, sen_cnt;
    bit          done;

    always #5 clk = ~clk;

    dft_scan_unloader #(.p_chain_len(100), .p_word_width(32)) u_dut100 (
        .clk(clk), .reset(rst_n),
        .dft_val_op(val_op[0]), .dft_op_ack(ack[0]),
        .dft_op_commit(commit[0]), .dft_commit_ack(commit_ack[0]),
        .dft_output_strobe(strb[0]), .dft_output_data(data[0]),
        .scan_en(sen[0]), .scan_out(sout[0]), .scan_in(sin[0])
    );

    dft_scan_unloader #(.p_chain_len(64), .p_word_width(32)) u_dut64 (
        .clk(clk), .reset(rst_n),
        .dft_val_op(val_op[1]), .dft_op_ack(ack[1]),
        .dft_op_commit(commit[1]), .dft_commit_ack(commit_ack[1]),
        .dft_output_strobe(strb[1]), .dft_output_data(data[1]),
        .scan_en(sen[1]), .scan_out(sout[1]), .scan_in(sin[1])
    );

    // Scan chain models: element 0 is the tail, new bits enter at the head.
    assign sout[0] = ch100[0];
    assign sout[1] = ch64[0];

    always @(posedge clk) begin
        if (ld_req[0])   ch100 <= ld100;
        else if (sen[0]) ch100 <= {sin[0], ch100[99:1]};
    end

    always @(posedge clk) begin
        if (ld_req[1])   ch64 <= ld64;
        else if (sen[1]) ch64 <= {sin[1], ch64[63:1]};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_chain(input int d, input logic [99:0] v);
        if (d == 0) ld100 = v;
        else        ld64  = v[63:0];
        ld_req[d] = 1'b1;
        step();
        ld_req[d] = 1'b0;
    endtask

    // Requests one unload on instance d and records strobes and handshake timing,
    // with cycle numbers counted from T0 (the cycle val_op is first sampled).
    // commit_len is the number of cycles commit stays high; ack is driven in the last one.
    task automatic run_unload(input int d, input bit hold_val, input int commit_len);
        int ccount;
        n_strb = 0; commit_cyc = -1; end_cyc = -1; ack_cnt = 0; ack_cyc = -1;
        overlap = 0; sen_cnt = 0; ccount = 0; done = 0;
        commit_ack[d] = 1'b0;
        val_op[d] = 1'b1;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            step();
            if (!hold_val) val_op[d] = 1'b0;
            if (ack[d]) begin
                if (ack_cyc < 0) ack_cyc = cyc;
                ack_cnt++;
            end
            if (sen[d]) sen_cnt++;
            if (strb[d]) begin
                if (n_strb < 8) begin
                    words[n_strb] = data[d];
                    scyc[n_strb]  = cyc;
                end
                n_strb++;
            end
            if (commit[d]) begin
                if (commit_cyc < 0) commit_cyc = cyc;
                if (strb[d]) overlap++;
                ccount++;
                if (ccount == commit_len) commit_ack[d] = 1'b1;
            end else if (ccount > 0) begin
                done = 1;
                end_cyc = cyc;
                commit_ack[d] = 1'b0;
            end
        end
        commit_ack[d] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL unload_timeout: dut %0d never returned to idle, done=%0d expected 1", d, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; val_op = '0; commit_ack = '0; ld_req = '0; ld100 = '0; ld64 = '0;
        step(); step();
        checks++; if (ack !== 2'b00)    begin errors++; $display("FAIL reset_ack: got %b expected 00", ack); end
        checks++; if (commit !== 2'b00) begin errors++; $display("FAIL reset_commit: got %b expected 00", commit); end
        checks++; if (strb !== 2'b00)   begin errors++; $display("FAIL reset_strobe: got %b expected 00", strb); end
        checks++; if (sen !== 2'b00)    begin errors++; $display("FAIL reset_scan_en: got %b expected 00", sen); end
        checks++; if (data[0] !== 32'h0) begin errors++; $display("FAIL reset_data0: got %h expected 0", data[0]); end
        checks++; if (data[1] !== 32'h0) begin errors++; $display("FAIL reset_data1: got %h expected 0", data[1]); end
        load_chain(0, 100'd1);
        checks++; if (sin[0] !== 1'b1) begin errors++; $display("FAIL scan_in_follow1: got %b expected 1", sin[0]); end
        load_chain(0, 100'd2);
        checks++; if (sin[0] !== 1'b0) begin errors++; $display("FAIL scan_in_follow0: got %b expected 0", sin[0]); end
        rst_n = 1'b1;
        step();
        checks++; if ({ack, commit, strb, sen} !== 8'h00) begin errors++; $display("FAIL idle_outputs: got %h expected 00", {ack, commit, strb, sen}); end
    endtask

    task automatic test_partial_word();
        logic [99:0] pat;
        logic [31:0] ew [4];
        int          ec [4];
        pat = {4'b1010, 32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};
        ew  = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0000000A};
        ec  = '{34, 66, 98, 102};
        load_chain(0, pat);
        run_unload(0, 1'b0, 1);
        checks++; if (n_strb !== 4) begin errors++; $display("FAIL partial_strobe_count: got %0d expected 4", n_strb); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (words[k] !== ew[k]) begin errors++; $display("FAIL partial_word%0d: got %h expected %h", k, words[k], ew[k]); end
            checks++; if (scyc[k] !== ec[k]) begin errors++; $display("FAIL partial_strobe_cycle%0d: got %0d expected %0d", k, scyc[k], ec[k]); end
        end
        checks++; if (ack_cyc !== 1)      begin errors++; $display("FAIL partial_ack_cycle: got %0d expected 1", ack_cyc); end
        checks++; if (sen_cnt !== 100)    begin errors++; $display("FAIL partial_scan_en_cycles: got %0d expected 100", sen_cnt); end
        checks++; if (commit_cyc !== 103) begin errors++; $display("FAIL partial_commit_cycle: got %0d expected 103", commit_cyc); end
        checks++; if (end_cyc !== 104)    begin errors++; $display("FAIL partial_idle_cycle: got %0d expected 104", end_cyc); end
        checks++; if (overlap !== 0)      begin errors++; $display("FAIL partial_strobe_commit_overlap: got %0d expected 0", overlap); end
        checks++; if (ch100 !== pat)      begin errors++; $display("FAIL partial_chain_restored: got %h expected %h", ch100, pat); end
    endtask

    task automatic test_exact_multiple();
        logic [99:0] pat;
        pat = {36'h0, 32'h00000001, 32'hFFFFFFFF};
        load_chain(1, pat);
        run_unload(1, 1'b0, 1);
        checks++; if (n_strb !== 2)          begin errors++; $display("FAIL exact_strobe_count: got %0d expected 2", n_strb); end
        checks++; if (words[0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL exact_word0: got %h expected ffffffff", words[0]); end
        checks++; if (words[1] !== 32'h00000001) begin errors++; $display("FAIL exact_word1: got %h expected 00000001", words[1]); end
        checks++; if (scyc[0] !== 34)        begin errors++; $display("FAIL exact_strobe_cycle0: got %0d expected 34", scyc[0]); end
        checks++; if (scyc[1] !== 66)        begin errors++; $display("FAIL exact_strobe_cycle1: got %0d expected 66", scyc[1]); end
        checks++; if (commit_cyc !== 67)     begin errors++; $display("FAIL exact_commit_cycle: got %0d expected 67", commit_cyc); end
        checks++; if (ch64 !== pat[63:0])    begin errors++; $display("FAIL exact_chain_restored: got %h expected %h", ch64, pat[63:0]); end
    endtask

    task automatic test_delayed_commit();
        load_chain(0, {4'b0011, 32'h0F0F0F0F, 32'h80000001, 32'h55AA55AA});
        run_unload(0, 1'b0, 10);
        checks++; if (commit_cyc !== 103) begin errors++; $display("FAIL delayed_commit_rise: got %0d expected 103", commit_cyc); end
        checks++; if (end_cyc !== 113)    begin errors++; $display("FAIL delayed_commit_idle: got %0d expected 113", end_cyc); end
        checks++; if (ack_cnt !== 1)      begin errors++; $display("FAIL delayed_ack_pulses: got %0d expected 1", ack_cnt); end
        checks++; if (words[1] !== 32'h80000001) begin errors++; $display("FAIL delayed_word1: got %h expected 80000001", words[1]); end
        checks++; if (words[3] !== 32'h00000003) begin errors++; $display("FAIL delayed_word3: got %h expected 00000003", words[3]); end
    endtask

    task automatic test_reset_mid_shift();
        load_chain(0, {4'b1111, 32'hFFFFFFFF, 32'h12345678, 32'hDEADBEEF});
        val_op[0] = 1'b1;
        step();
        val_op[0] = 1'b0;
        repeat (41) step();
        checks++; if (sen[0] !== 1'b1) begin errors++; $display("FAIL midshift_scan_en_before: got %b expected 1", sen[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sen[0] !== 1'b0)    begin errors++; $display("FAIL midshift_scan_en_async: got %b expected 0", sen[0]); end
        checks++; if (strb[0] !== 1'b0)   begin errors++; $display("FAIL midshift_strobe_async: got %b expected 0", strb[0]); end
        checks++; if (commit[0] !== 1'b0) begin errors++; $display("FAIL midshift_commit_async: got %b expected 0", commit[0]); end
        checks++; if (data[0] !== 32'h0)  begin errors++; $display("FAIL midshift_data_async: got %h expected 0", data[0]); end
        step();
        rst_n = 1'b1;
        step();
        load_chain(0, {4'b0000, 32'h0, 32'h0, 32'h0000FFFF});
        run_unload(0, 1'b0, 1);
        checks++; if (n_strb !== 4)              begin errors++; $display("FAIL restart_strobe_count: got %0d expected 4", n_strb); end
        checks++; if (words[0] !== 32'h0000FFFF) begin errors++; $display("FAIL restart_word0: got %h expected 0000ffff", words[0]); end
        checks++; if (words[1] !== 32'h0)        begin errors++; $display("FAIL restart_word1: got %h expected 0", words[1]); end
        checks++; if (scyc[0] !== 34)            begin errors++; $display("FAIL restart_strobe_cycle0: got %0d expected 34", scyc[0]); end
    endtask

    task automatic test_ignored_and_back_to_back();
        commit_ack[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({ack[0], commit[0], sen[0], strb[0]} !== 4'b0000) begin
                errors++; $display("FAIL idle_commit_ack_ignored%0d: got %b expected 0000", i, {ack[0], commit[0], sen[0], strb[0]});
            end
        end
        commit_ack[0] = 1'b0;
        step();
        load_chain(0, {4'b1000, 32'h00000000, 32'hFFFF0000, 32'h00000001});
        run_unload(0, 1'b1, 1);
        checks++; if (ack_cnt !== 1)  begin errors++; $display("FAIL held_ack_pulses: got %0d expected 1", ack_cnt); end
        checks++; if (end_cyc !== 104) begin errors++; $display("FAIL held_idle_cycle: got %0d expected 104", end_cyc); end
        checks++; if (words[3] !== 32'h00000008) begin errors++; $display("FAIL held_word3: got %h expected 00000008", words[3]); end
        step();
        checks++; if (ack[0] !== 1'b1) begin errors++; $display("FAIL back_to_back_ack: got %b expected 1", ack[0]); end
        val_op[0] = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_recirculation();
        logic [127:0] r;
        logic [99:0]  pat;
        logic [127:0] ex;
        r   = {$urandom(), $urandom(), $urandom(), $urandom()};
        pat = r[99:0];
        ex  = {28'h0, pat};
        load_chain(0, pat);
        for (int pass = 0; pass < 2; pass++) begin
            run_unload(0, 1'b0, 1);
            checks++; if (n_strb !== 4) begin errors++; $display("FAIL recirc_count_pass%0d: got %0d expected 4", pass, n_strb); end
            for (int k = 0; k < 4; k++) begin
                checks++; if (words[k] !== ex[32*k +: 32]) begin
                    errors++; $display("FAIL recirc_pass%0d_word%0d: got %h expected %h", pass, k, words[k], ex[32*k +: 32]);
                end
            end
            step();
        end
        checks++; if (ch100 !== pat) begin errors++; $display("FAIL recirc_chain_restored: got %h expected %h", ch100, pat); end
    endtask

    initial begin
        test_reset();
        test_partial_word();
        test_exact_multiple();
        test_delayed_commit();
        test_reset_mid_shift();
        test_ignored_and_back_to_back();
        test_recirculation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
